// File: rtl/si_issue_if.sv
// si_issue_if: decode/execute issue-control bundle for si_issue_ctrl.
//   master : decode side, drives the decoded instruction fields and redirect,
//            observes issue/stall/flush, multiplier busy, pending map and
//            the stall counter.
//   slave  : issue controller, the mirror image of master.
// Parameters: REG_AW register address width, CNT_W stall counter width.
interface si_issue_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) ();
  logic              id_valid_i;
  logic              rs1_en_i;
  logic [REG_AW-1:0] rs1_addr_i;
  logic              rs2_en_i;
  logic [REG_AW-1:0] rs2_addr_i;
  logic              id_wb_en_i;
  logic [REG_AW-1:0] id_wb_addr_i;
  logic              is_load_i;
  logic              is_mul_i;
  logic              redirect_i;
  logic              issue_o;
  logic              stall_o;
  logic              flush_o;
  logic              mul_busy_o;
  logic [31:0]       pending_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  modport master (
    output id_valid_i, rs1_en_i, rs1_addr_i, rs2_en_i, rs2_addr_i,
           id_wb_en_i, id_wb_addr_i, is_load_i, is_mul_i, redirect_i,
    input  issue_o, stall_o, flush_o, mul_busy_o, pending_o, stall_cnt_o
  );

  modport slave (
    input  id_valid_i, rs1_en_i, rs1_addr_i, rs2_en_i, rs2_addr_i,
           id_wb_en_i, id_wb_addr_i, is_load_i, is_mul_i, redirect_i,
    output issue_o, stall_o, flush_o, mul_busy_o, pending_o, stall_cnt_o
  );
endinterface

// File: rtl/si_issue_ctrl.sv
// si_issue_ctrl: issue/hazard controller between decode and execute of the
// single-issue RV32IM core. Tracks outstanding LW/MUL writes with a
// per-register latency scoreboard, sequences the shared non-pipelined
// multiplier and decides each cycle whether the decode instruction issues,
// stalls or is flushed by a taken branch/jump.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  si_issue_if.slave: decoded instruction fields and redirect in;
//        issue/stall/flush, mul_busy, pending register map and saturating
//        stall-cycle counter out.
module si_issue_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LAT_W    = 3,
  parameter int LOAD_LAT = 2,
  parameter int MUL_LAT  = 4,
  parameter int CNT_W    = 32
) (
  input  logic         clk,
  input  logic         rst,
  si_issue_if.slave    bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mul_state_t;

  localparam logic [LAT_W-1:0] LOAD_SET = LAT_W'(LOAD_LAT - 1);
  localparam logic [LAT_W-1:0] MUL_SET  = LAT_W'(MUL_LAT - 1);
  // A single-cycle multiplier never occupies the unit past its issue cycle.
  localparam logic             MUL_MULTI = (MUL_LAT > 1) ? 1'b1 : 1'b0;

  // x0 has no counter: it can never be pending.
  logic [LAT_W-1:0] cnt_r [1:31];
  mul_state_t       mul_state_r;
  logic [LAT_W-1:0] mul_cnt_r;
  logic [CNT_W-1:0] stall_cnt_r;

  logic [31:0]      pending_s;
  logic             raw_s;
  logic             waw_s;
  logic             struct_s;
  logic             hazard_s;
  logic             issue_s;
  logic             stall_s;
  logic             flush_s;
  logic             set_s;
  logic [LAT_W-1:0] set_val_s;

  // Pending map straight from the counters; bit 0 stays clear.
  always_comb begin
    pending_s = 32'h0000_0000;
    for (int r = 1; r < 32; r++) begin
      pending_s[r] = (cnt_r[r] != {LAT_W{1'b0}});
    end
  end

  // Hazard detection on current counter values and multiplier state.
  always_comb begin
    raw_s    = (bus.rs1_en_i & (bus.rs1_addr_i != {REG_AW{1'b0}}) & pending_s[bus.rs1_addr_i])
             | (bus.rs2_en_i & (bus.rs2_addr_i != {REG_AW{1'b0}}) & pending_s[bus.rs2_addr_i]);
    waw_s    = bus.id_wb_en_i & (bus.id_wb_addr_i != {REG_AW{1'b0}}) & pending_s[bus.id_wb_addr_i];
    struct_s = bus.is_mul_i & (mul_state_r == BUSY);
    hazard_s = raw_s | waw_s | struct_s;
  end

  // Issue decision; outputs held low while reset is asserted.
  always_comb begin
    issue_s = bus.id_valid_i & ~bus.redirect_i & ~hazard_s & ~rst;
    stall_s = bus.id_valid_i & ~bus.redirect_i &  hazard_s & ~rst;
    flush_s = bus.id_valid_i &  bus.redirect_i & ~rst;
    set_s   = issue_s & bus.id_wb_en_i & (bus.id_wb_addr_i != {REG_AW{1'b0}})
            & (bus.is_load_i | bus.is_mul_i);
    if (bus.is_load_i) begin
      set_val_s = LOAD_SET;
    end else begin
      set_val_s = MUL_SET;
    end
  end

  // Scoreboard: load on a multi-cycle issue, otherwise count down to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r < 32; r++) begin
        cnt_r[r] <= {LAT_W{1'b0}};
      end
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (set_s && (bus.id_wb_addr_i == REG_AW'(r))) begin
          cnt_r[r] <= set_val_s;
        end else if (cnt_r[r] != {LAT_W{1'b0}}) begin
          cnt_r[r] <= cnt_r[r] - LAT_W'(1);
        end else begin
          cnt_r[r] <= cnt_r[r];
        end
      end
    end
  end

  // Multiplier occupancy FSM: busy for MUL_LAT-1 cycles after a MUL issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_state_r <= IDLE;
      mul_cnt_r   <= {LAT_W{1'b0}};
    end else begin
      case (mul_state_r)
        IDLE: begin
          if (issue_s && bus.is_mul_i && MUL_MULTI) begin
            mul_state_r <= BUSY;
            mul_cnt_r   <= MUL_SET;
          end else begin
            mul_state_r <= IDLE;
            mul_cnt_r   <= mul_cnt_r;
          end
        end
        BUSY: begin
          mul_cnt_r <= mul_cnt_r - LAT_W'(1);
          // Leave once the count would reach zero.
          if (mul_cnt_r == LAT_W'(1)) begin
            mul_state_r <= IDLE;
          end else begin
            mul_state_r <= BUSY;
          end
        end
        default: begin
          mul_state_r <= IDLE;
          mul_cnt_r   <= {LAT_W{1'b0}};
        end
      endcase
    end
  end

  // Saturating stall-cycle performance counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bus.issue_o     = issue_s;
  assign bus.stall_o     = stall_s;
  assign bus.flush_o     = flush_s;
  assign bus.mul_busy_o  = (mul_state_r == BUSY);
  assign bus.pending_o   = pending_s;
  assign bus.stall_cnt_o = stall_cnt_r;

endmodule

// File: tb/tb_si_issue_ctrl.sv
// Bench for si_issue_ctrl: directed table of decode patterns, hand-written
// reset-during-MUL sequence and random stimulus against a reference model
// based on absolute "ready at cycle" times. A second instance with a 3-bit
// stall counter shares the stimulus so that saturation is reached quickly.
module tb_si_issue_ctrl;
  localparam int LOAD_LAT = 2;
  localparam int MUL_LAT  = 4;
  localparam int SCW      = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  si_issue_if #(.REG_AW(5), .CNT_W(32))  bus   ();
  si_issue_if #(.REG_AW(5), .CNT_W(SCW)) bus_s ();

  assign bus_s.id_valid_i   = bus.id_valid_i;
  assign bus_s.rs1_en_i     = bus.rs1_en_i;
  assign bus_s.rs1_addr_i   = bus.rs1_addr_i;
  assign bus_s.rs2_en_i     = bus.rs2_en_i;
  assign bus_s.rs2_addr_i   = bus.rs2_addr_i;
  assign bus_s.id_wb_en_i   = bus.id_wb_en_i;
  assign bus_s.id_wb_addr_i = bus.id_wb_addr_i;
  assign bus_s.is_load_i    = bus.is_load_i;
  assign bus_s.is_mul_i     = bus.is_mul_i;
  assign bus_s.redirect_i   = bus.redirect_i;

  si_issue_ctrl #(.LOAD_LAT(LOAD_LAT), .MUL_LAT(MUL_LAT), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  si_issue_ctrl #(.LOAD_LAT(LOAD_LAT), .MUL_LAT(MUL_LAT), .CNT_W(SCW)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s));

  typedef struct {
    bit       v; bit r1e; bit [4:0] r1; bit r2e; bit [4:0] r2;
    bit       we; bit [4:0] rd; bit ld; bit mul; bit rdr;
    bit       e_iss; bit e_stl; bit e_fl; bit e_busy; bit [31:0] e_pend;
  } vec_t;

  vec_t tbl[$];

  // Reference model: a register is free from cycle ready[r] on, the
  // multiplier from cycle mul_free on.
  int     ready [32];
  int     mul_free;
  int     cyc;
  longint sc;
  int     n_vec;
  int     n_err;
  bit     m_iss, m_stl, m_fl, m_busy;
  logic [31:0] m_pend;

  function automatic vec_t mk(bit v, bit r1e, bit [4:0] r1, bit r2e, bit [4:0] r2,
                              bit we, bit [4:0] rd, bit ld, bit mul, bit rdr,
                              bit ei, bit es, bit ef, bit eb, bit [31:0] ep);
    vec_t t;
    t.v = v; t.r1e = r1e; t.r1 = r1; t.r2e = r2e; t.r2 = r2;
    t.we = we; t.rd = rd; t.ld = ld; t.mul = mul; t.rdr = rdr;
    t.e_iss = ei; t.e_stl = es; t.e_fl = ef; t.e_busy = eb; t.e_pend = ep;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    bus.id_valid_i   = t.v;
    bus.rs1_en_i     = t.r1e;
    bus.rs1_addr_i   = t.r1;
    bus.rs2_en_i     = t.r2e;
    bus.rs2_addr_i   = t.r2;
    bus.id_wb_en_i   = t.we;
    bus.id_wb_addr_i = t.rd;
    bus.is_load_i    = t.ld;
    bus.is_mul_i     = t.mul;
    bus.redirect_i   = t.rdr;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) ready[r] = 0;
    mul_free = 0;
    sc = 0;
  endtask

  // Compute the model's view of this cycle and compare both instances.
  task automatic model_check();
    bit haz;
    m_pend = 32'h0;
    for (int r = 1; r < 32; r++) m_pend[r] = (ready[r] > cyc);
    m_busy = (mul_free > cyc);
    haz = (bus.rs1_en_i && bus.rs1_addr_i != 5'd0 && ready[bus.rs1_addr_i] > cyc)
       || (bus.rs2_en_i && bus.rs2_addr_i != 5'd0 && ready[bus.rs2_addr_i] > cyc)
       || (bus.id_wb_en_i && bus.id_wb_addr_i != 5'd0 && ready[bus.id_wb_addr_i] > cyc)
       || (bus.is_mul_i && m_busy);
    m_fl  = bus.id_valid_i && bus.redirect_i;
    m_iss = bus.id_valid_i && !bus.redirect_i && !haz;
    m_stl = bus.id_valid_i && !bus.redirect_i && haz;
    chk("issue",     64'(bus.issue_o),      64'(m_iss));
    chk("stall",     64'(bus.stall_o),      64'(m_stl));
    chk("flush",     64'(bus.flush_o),      64'(m_fl));
    chk("mul_busy",  64'(bus.mul_busy_o),   64'(m_busy));
    chk("pending",   64'(bus.pending_o),    64'(m_pend));
    chk("stall_cnt", 64'(bus.stall_cnt_o),  64'(sc));
    chk("stall_cnt_sat", 64'(bus_s.stall_cnt_o), 64'((sc > 7) ? 7 : sc));
  endtask

  task automatic model_update();
    if (m_iss && bus.id_wb_en_i && bus.id_wb_addr_i != 5'd0) begin
      if (bus.is_load_i) ready[bus.id_wb_addr_i] = cyc + LOAD_LAT;
      else if (bus.is_mul_i) ready[bus.id_wb_addr_i] = cyc + MUL_LAT;
    end
    if (m_iss && bus.is_mul_i) mul_free = cyc + MUL_LAT;
    if (m_stl) sc++;
    cyc++;
  endtask

  // Called at posedge+1 with inputs already driven.
  task automatic step(input bit use_tbl, input vec_t t);
    #2;
    model_check();
    if (use_tbl) begin
      chk("tbl_issue",   64'(bus.issue_o),    64'(t.e_iss));
      chk("tbl_stall",   64'(bus.stall_o),    64'(t.e_stl));
      chk("tbl_flush",   64'(bus.flush_o),    64'(t.e_fl));
      chk("tbl_busy",    64'(bus.mul_busy_o), 64'(t.e_busy));
      chk("tbl_pending", 64'(bus.pending_o),  64'(t.e_pend));
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  vec_t idle, tv;
  int   ty;

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    idle = mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,32'h0);
    drive(idle);
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_pending",   64'(bus.pending_o),   64'h0);
    chk("rst_busy",      64'(bus.mul_busy_o),  64'h0);
    chk("rst_stall_cnt", 64'(bus.stall_cnt_o), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset during an in-flight MUL x7 with a dependent instruction stalled.
    drive(mk(1,0,0,0,0,1,7,0,1,0, 0,0,0,0,0));
    step(0, idle);
    drive(mk(1,1,7,0,0,0,0,0,0,0, 0,0,0,0,0));
    #2;
    chk("pre_rst_stall", 64'(bus.stall_o),    64'h1);
    chk("pre_rst_busy",  64'(bus.mul_busy_o), 64'h1);
    #1 rst = 1'b1;
    #1;
    chk("async_pending", 64'(bus.pending_o),  64'h0);
    chk("async_busy",    64'(bus.mul_busy_o), 64'h0);
    chk("async_stall",   64'(bus.stall_o),    64'h0);
    chk("async_issue",   64'(bus.issue_o),    64'h0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    step(0, idle);   // first instruction after reset must issue

    // Directed table.
    tbl.push_back(mk(1,0,0,0,0,1,5,1,0,0, 1,0,0,0,32'h0));        // LW x5
    tbl.push_back(mk(1,1,5,1,1,1,6,0,0,0, 0,1,0,0,32'h20));       // ADD x6,x5,x1 stalls
    tbl.push_back(mk(1,1,5,1,1,1,6,0,0,0, 1,0,0,0,32'h0));        // then issues
    tbl.push_back(mk(1,0,0,0,0,1,3,0,1,0, 1,0,0,0,32'h0));        // MUL x3
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1,0,0,0,0,1,4,0,1,0, 0,1,0,1,32'h8));      // MUL x4 structural
    tbl.push_back(mk(1,0,0,0,0,1,4,0,1,0, 1,0,0,0,32'h0));        // MUL x4 issues
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,1,32'h10));
    tbl.push_back(mk(1,0,0,0,0,1,8,0,1,0, 1,0,0,0,32'h0));        // MUL x8
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1,1,2,1,8,0,0,0,0,0, 0,1,0,1,32'h100));    // SW reads x8
    tbl.push_back(mk(1,1,2,1,8,0,0,0,0,0, 1,0,0,0,32'h0));
    tbl.push_back(mk(1,1,1,0,0,1,9,0,0,0, 1,0,0,0,32'h0));        // ADDI x9
    tbl.push_back(mk(1,0,0,0,0,1,8,0,1,0, 1,0,0,0,32'h0));        // MUL x8
    tbl.push_back(mk(1,1,2,0,8,0,0,0,0,0, 1,0,0,1,32'h100));      // rs2_en=0: no stall
    tbl.push_back(mk(1,0,0,0,0,1,5,1,0,0, 1,0,0,1,32'h100));      // LW x5
    tbl.push_back(mk(1,1,5,0,0,1,2,0,0,1, 0,0,1,1,32'h120));      // ADD x2,x5 flushed
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1, 0,0,0,0,32'h0));        // redirect, no valid
    tbl.push_back(mk(1,0,0,0,0,1,5,1,0,0, 1,0,0,0,32'h0));        // LW x5
    tbl.push_back(mk(1,0,0,0,0,1,5,1,0,0, 0,1,0,0,32'h20));       // LW x5 WAW
    tbl.push_back(mk(1,0,0,0,0,1,5,1,0,0, 1,0,0,0,32'h0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,32'h20));
    tbl.push_back(mk(1,0,0,0,0,1,0,1,0,0, 1,0,0,0,32'h0));        // LW x0
    tbl.push_back(mk(1,1,0,1,0,1,0,0,0,0, 1,0,0,0,32'h0));        // reads of x0
    tbl.push_back(mk(1,0,0,0,0,1,0,0,1,0, 1,0,0,0,32'h0));        // MUL x0
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,1,32'h0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,32'h0));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      step(1, tbl[i]);
    end

    // Random traffic on a small register window to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      ty = int'($urandom_range(0, 2));
      tv = idle;
      tv.v   = ($urandom_range(0, 9) < 8);
      tv.r1e = 1'($urandom);
      tv.r1  = 5'($urandom_range(0, 7));
      tv.r2e = 1'($urandom);
      tv.r2  = 5'($urandom_range(0, 7));
      tv.we  = ($urandom_range(0, 3) != 0);
      tv.rd  = 5'($urandom_range(0, 7));
      tv.ld  = (ty == 1);
      tv.mul = (ty == 2);
      tv.rdr = ($urandom_range(0, 9) == 0);
      drive(tv);
      step(0, idle);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
